// File: rtl/fc_addrgener_param_2.sv
// Address generator for the FC layer engine: sweeps the input-neuron buffer two words per
// beat for every output-neuron group, with a linear weight address and accumulator flags.
module fc_addrgener_param_2 #(
  parameter int FC_INNEURON_ADDR_WIDTH = 10,
  parameter int FC_WEIGHT_ADDR_WIDTH   = 11,
  parameter int FC_GROUP_WIDTH         = 4,
  parameter int INNEURON               = 1024,
  parameter int OUTNEURON              = 64,
  parameter int PI                     = 4,
  parameter int PO                     = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              enable,
  output logic                              busy,
  output logic [FC_INNEURON_ADDR_WIDTH-1:0] addra,
  output logic [FC_INNEURON_ADDR_WIDTH-1:0] addrb,
  output logic                              valid,
  output logic                              valid_b,
  output logic [FC_WEIGHT_ADDR_WIDTH-1:0]   weight_addr,
  output logic [FC_GROUP_WIDTH-1:0]         group_idx,
  output logic                              acc_clear,
  output logic                              acc_last,
  output logic                              done,
  output logic [1:0]                        state_dbg
);

  localparam int AW = FC_INNEURON_ADDR_WIDTH;
  localparam int WW = FC_WEIGHT_ADDR_WIDTH;
  localparam int GW = FC_GROUP_WIDTH;
  localparam int D  = INNEURON / PI;
  localparam int B  = (D + 1) / 2;
  localparam int G  = OUTNEURON / PO;

  localparam logic [AW-1:0] K_LAST  = AW'(B - 1);
  localparam logic [GW-1:0] G_LAST  = GW'(G - 1);
  localparam logic [AW:0]   D_WORDS = (AW + 1)'(D);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   k_q, k_d;
  logic [GW-1:0]   g_q, g_d;
  logic [WW-1:0]   w_q, w_d;

  logic [AW-1:0]   addra_q, addra_d;
  logic [AW-1:0]   addrb_q, addrb_d;
  logic            valid_q, valid_d;
  logic            valid_b_q, valid_b_d;
  logic [WW-1:0]   weight_addr_q, weight_addr_d;
  logic [GW-1:0]   group_idx_q, group_idx_d;
  logic            acc_clear_q, acc_clear_d;
  logic            acc_last_q, acc_last_d;
  logic            done_q, done_d;

  // Odd word of the current beat, one bit wider so 2k+1 == D is representable.
  logic [AW:0]     odd_word;
  logic            beat_last;
  logic            pass_last;

  assign odd_word  = {k_q, 1'b1};
  assign beat_last = (k_q == K_LAST);
  assign pass_last = beat_last && (g_q == G_LAST);

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    g_d           = g_q;
    w_d           = w_q;
    addra_d       = addra_q;
    addrb_d       = addrb_q;
    weight_addr_d = weight_addr_q;
    group_idx_d   = group_idx_q;
    valid_d       = 1'b0;
    valid_b_d     = 1'b0;
    acc_clear_d   = 1'b0;
    acc_last_d    = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          k_d     = '0;
          g_d     = '0;
          w_d     = '0;
        end
      end

      S_RUN: begin
        if (enable) begin
          valid_d       = 1'b1;
          addra_d       = {k_q[AW-2:0], 1'b0};
          valid_b_d     = (odd_word < D_WORDS);
          addrb_d       = (odd_word < D_WORDS) ? odd_word[AW-1:0] : '0;
          weight_addr_d = w_q;
          group_idx_d   = g_q;
          acc_clear_d   = (k_q == '0);
          acc_last_d    = beat_last;

          // Counters stop on the final beat so they never leave their legal range.
          if (pass_last) begin
            state_d = S_DONE;
          end else begin
            w_d = w_q + WW'(1);
            if (beat_last) begin
              k_d = '0;
              g_d = g_q + GW'(1);
            end else begin
              k_d = k_q + AW'(1);
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      g_q           <= '0;
      w_q           <= '0;
      addra_q       <= '0;
      addrb_q       <= '0;
      valid_q       <= 1'b0;
      valid_b_q     <= 1'b0;
      weight_addr_q <= '0;
      group_idx_q   <= '0;
      acc_clear_q   <= 1'b0;
      acc_last_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      g_q           <= g_d;
      w_q           <= w_d;
      addra_q       <= addra_d;
      addrb_q       <= addrb_d;
      valid_q       <= valid_d;
      valid_b_q     <= valid_b_d;
      weight_addr_q <= weight_addr_d;
      group_idx_q   <= group_idx_d;
      acc_clear_q   <= acc_clear_d;
      acc_last_q    <= acc_last_d;
      done_q        <= done_d;
    end
  end

  // busy comes straight from the state flop, so it drops in the same cycle done pulses.
  assign busy        = (state_q != S_IDLE);
  assign addra       = addra_q;
  assign addrb       = addrb_q;
  assign valid       = valid_q;
  assign valid_b     = valid_b_q;
  assign weight_addr = weight_addr_q;
  assign group_idx   = group_idx_q;
  assign acc_clear   = acc_clear_q;
  assign acc_last    = acc_last_q;
  assign done        = done_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fc_addrgener_param_2.sv
// Directed bench for fc_addrgener_param_2: default geometry, odd depth (D=5) and D=1 instances.
module tb_fc_addrgener_param_2;

  localparam int B_BIG = 128;
  localparam int TOTAL = 2048;
  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_DONE = 2;

  logic clk;
  logic rst_n;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: D=256, B=128, G=16
  logic       b_start, b_en;
  logic       b_busy, b_valid, b_valid_b, b_clr, b_last, b_done;
  logic [9:0] b_addra, b_addrb;
  logic [10:0] b_w;
  logic [3:0] b_g;
  logic [1:0] b_dbg;

  fc_addrgener_param_2 u_big (
    .clk(clk), .reset(rst_n), .start(b_start), .enable(b_en),
    .busy(b_busy), .addra(b_addra), .addrb(b_addrb), .valid(b_valid), .valid_b(b_valid_b),
    .weight_addr(b_w), .group_idx(b_g), .acc_clear(b_clr), .acc_last(b_last), .done(b_done),
    .state_dbg(b_dbg)
  );

  // Odd-depth instance: D=5, B=3, G=2
  logic       s5_start, s5_en;
  logic       s5_busy, s5_valid, s5_valid_b, s5_clr, s5_last, s5_done;
  logic [9:0] s5_addra, s5_addrb;
  logic [10:0] s5_w;
  logic [3:0] s5_g;
  logic [1:0] s5_dbg;

  fc_addrgener_param_2 #(.INNEURON(20), .PI(4), .OUTNEURON(8), .PO(4)) u_d5 (
    .clk(clk), .reset(rst_n), .start(s5_start), .enable(s5_en),
    .busy(s5_busy), .addra(s5_addra), .addrb(s5_addrb), .valid(s5_valid), .valid_b(s5_valid_b),
    .weight_addr(s5_w), .group_idx(s5_g), .acc_clear(s5_clr), .acc_last(s5_last), .done(s5_done),
    .state_dbg(s5_dbg)
  );

  // Single-word instance: D=1, B=1, G=3
  logic       s1_start, s1_en;
  logic       s1_busy, s1_valid, s1_valid_b, s1_clr, s1_last, s1_done;
  logic [9:0] s1_addra, s1_addrb;
  logic [10:0] s1_w;
  logic [3:0] s1_g;
  logic [1:0] s1_dbg;

  fc_addrgener_param_2 #(.INNEURON(4), .PI(4), .OUTNEURON(12), .PO(4)) u_d1 (
    .clk(clk), .reset(rst_n), .start(s1_start), .enable(s1_en),
    .busy(s1_busy), .addra(s1_addra), .addrb(s1_addrb), .valid(s1_valid), .valid_b(s1_valid_b),
    .weight_addr(s1_w), .group_idx(s1_g), .acc_clear(s1_clr), .acc_last(s1_last), .done(s1_done),
    .state_dbg(s1_dbg)
  );

  // Observation vectors: {busy,done,valid,valid_b,acc_clear,acc_last,addra,addrb,weight_addr,group_idx}
  logic [40:0] obs_b, obs_5, obs_1;
  assign obs_b = {b_busy, b_done, b_valid, b_valid_b, b_clr, b_last, b_addra, b_addrb, b_w, b_g};
  assign obs_5 = {s5_busy, s5_done, s5_valid, s5_valid_b, s5_clr, s5_last, s5_addra, s5_addrb, s5_w, s5_g};
  assign obs_1 = {s1_busy, s1_done, s1_valid, s1_valid_b, s1_clr, s1_last, s1_addra, s1_addrb, s1_w, s1_g};

  int n_total = 0;
  int n_bad   = 0;

  // Last issued fields of the default instance (outputs hold these between beats)
  int h_a = 0, h_b = 0, h_w = 0, h_g = 0;

  function automatic logic [40:0] mk(input logic busy, input logic dn, input logic v, input logic vb,
                                     input logic clr, input logic last,
                                     input int a, input int b, input int w, input int g);
    return {busy, dn, v, vb, clr, last, 10'(a), 10'(b), 11'(w), 4'(g)};
  endfunction

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [40:0] obs, input logic [40:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one pass of the default instance and checks every cycle against the model.
  // mode 0: enable held high; mode 1: enable pattern 1,0,0,1.
  task automatic run_big(input int mode, input bit inject, input int abort_at);
    int n, cyc, k, prev, mst;
    bit issue;
    logic [40:0] exp;
    n = 0;
    mst = ST_RUN;
    @(negedge clk);
    b_start = 1'b1;
    b_en = 1'($urandom_range(0, 1));
    exp = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, h_a, h_b, h_w, h_g);
    for (cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      b_start = 1'b0;
      chk($sformatf("big_m%0d_i%0d_c%0d", mode, inject, cyc), obs_b, exp);
      if (mst == ST_IDLE) break;
      if (abort_at >= 0 && n == abort_at) begin
        rst_n = 1'b0;
        #1;
        h_a = 0; h_b = 0; h_w = 0; h_g = 0;
        chk("abort_async", obs_b, '0);
        @(negedge clk);
        chk("abort_hold_no_done", obs_b, '0);
        rst_n = 1'b1;
        return;
      end
      prev = mst;
      issue = 1'b0;
      if (mst == ST_RUN) begin
        b_en = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
        issue = b_en;
        if (inject && (n == 10 || n == 500)) b_start = 1'b1;
      end else begin
        b_en = 1'($urandom_range(0, 1));
      end
      k = n % B_BIG;
      if (issue) begin
        h_a = 2 * k;
        h_b = 2 * k + 1;
        h_w = n;
        h_g = n / B_BIG;
        n++;
        if (n == TOTAL) mst = ST_DONE;
      end else if (mst == ST_DONE) begin
        mst = ST_IDLE;
      end
      exp = mk(mst != ST_IDLE, prev == ST_DONE, issue, issue,
               issue && (k == 0), issue && (k == B_BIG - 1), h_a, h_b, h_w, h_g);
    end
    chk($sformatf("big_pass_complete_m%0d", mode), 41'(n), 41'(TOTAL));
  endtask

  logic [40:0] exp5 [0:8];
  logic [40:0] exp1 [0:5];

  initial begin
    rst_n = 1'b0;
    b_start = 1'b0;  b_en = 1'b0;
    s5_start = 1'b0; s5_en = 1'b0;
    s1_start = 1'b0; s1_en = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_big", obs_b, '0);
    chk("reset_d5", obs_5, '0);
    chk("reset_d1", obs_1, '0);
    rst_n = 1'b1;

    // Odd depth D=5: beats (0,1),(2,3),(4,-) per group, two groups
    exp5[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp5[1] = mk(1, 0, 1, 1, 1, 0, 0, 1, 0, 0);
    exp5[2] = mk(1, 0, 1, 1, 0, 0, 2, 3, 1, 0);
    exp5[3] = mk(1, 0, 1, 0, 0, 1, 4, 0, 2, 0);
    exp5[4] = mk(1, 0, 1, 1, 1, 0, 0, 1, 3, 1);
    exp5[5] = mk(1, 0, 1, 1, 0, 0, 2, 3, 4, 1);
    exp5[6] = mk(1, 0, 1, 0, 0, 1, 4, 0, 5, 1);
    exp5[7] = mk(0, 1, 0, 0, 0, 0, 4, 0, 5, 1);
    exp5[8] = mk(0, 0, 0, 0, 0, 0, 4, 0, 5, 1);
    @(negedge clk);
    s5_start = 1'b1;
    s5_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      s5_start = 1'b0;
      chk($sformatf("d5_step%0d", i), obs_5, exp5[i]);
    end
    s5_en = 1'b0;

    // D=1: one beat per group, each both first and last
    exp1[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp1[1] = mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    exp1[2] = mk(1, 0, 1, 0, 1, 1, 0, 0, 1, 1);
    exp1[3] = mk(1, 0, 1, 0, 1, 1, 0, 0, 2, 2);
    exp1[4] = mk(0, 1, 0, 0, 0, 0, 0, 0, 2, 2);
    exp1[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 2);
    @(negedge clk);
    s1_start = 1'b1;
    s1_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s1_start = 1'b0;
      chk($sformatf("d1_step%0d", i), obs_1, exp1[i]);
    end
    s1_en = 1'b0;

    // Default geometry: full pass, stalled pass, start-during-run pass
    run_big(0, 1'b0, -1);
    run_big(1, 1'b0, -1);
    run_big(0, 1'b1, -1);

    // Mid-pass reset abort, then a fresh pass from zero
    run_big(0, 1'b0, 300);
    run_big(0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fc_addrgener_param_2.md
Name: fc_addrgener_param_2

Overview:
- Parametrised next-generation address generator for the fully-connected layer engine.
- Sweeps the input-neuron buffer two words per beat (dual read ports A/B) once for every output-neuron group.
- Also produces the matching linear weight-buffer address and accumulator control flags (clear, last, group index).
- Adds a start/done handshake, enable-driven stalling and odd-depth handling; sits between the FC controller and the neuron/weight BRAMs feeding the PI×PO MAC array.

Parameters:
FC_INNEURON_ADDR_WIDTH, 10, width of addra/addrb
FC_WEIGHT_ADDR_WIDTH, 11, width of weight_addr
FC_GROUP_WIDTH, 4, width of group_idx
INNEURON, 1024, input neurons per layer
OUTNEURON, 64, output neurons per layer
PI, 4, input neurons per buffer word
PO, 4, output neurons computed per group
Derived: D = INNEURON/PI words; B = ceil(D/2) beats per group; G = OUTNEURON/PO groups. Legal only if PI divides INNEURON, PO divides OUTNEURON, D>=1, and widths hold D-1, G*B-1, G-1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse: begin one full layer pass; sampled only in IDLE
enable  input  1  beat-issue permission; 0 stalls the sweep
busy  output  1  high from the cycle after start is accepted until done
addra  output  FC_INNEURON_ADDR_WIDTH  even-word read address, port A
addrb  output  FC_INNEURON_ADDR_WIDTH  odd-word read address, port B
valid  output  1  addra/weight_addr/flags meaningful this cycle
valid_b  output  1  addrb meaningful this cycle
weight_addr  output  FC_WEIGHT_ADDR_WIDTH  linear weight word address
group_idx  output  FC_GROUP_WIDTH  current output-neuron group
acc_clear  output  1  first beat of a group
acc_last  output  1  last beat of a group
done  output  1  one-cycle pulse: layer pass finished

Behaviour:
- Reset (reset=0, asynchronous) forces state IDLE. All outputs and counters go to 0, including addrb; busy=0, done=0.
- States:
  - IDLE: start=1 -> RUN; beat counter k=0, group counter g=0, weight counter w=0.
  - RUN: each cycle with enable=1 issues one beat, then advances. If k<B-1, k++; else k=0 and g++. w++ every beat. After issuing beat k=B-1 of g=G-1, go to DONE.
  - DONE: one cycle, then IDLE.
- start outside IDLE is ignored. enable is ignored outside RUN.
- Issued beat contents:
  - addra = 2k; addrb = 2k+1; weight_addr = w = g*B+k; group_idx = g.
  - acc_clear = (k==0); acc_last = (k==B-1).
  - valid_b = 1 unless 2k+1 >= D (odd D, final beat). When valid_b=0, addrb is driven 0.
- Latency: all issue outputs are registered and appear exactly one clock after the issuing edge.
- Stall: in a cycle with no beat issued (stall, IDLE, DONE), the next cycle shows valid=valid_b=acc_clear=acc_last=0. addra/addrb/weight_addr/group_idx hold their last values.
- busy = 1 while state is RUN or DONE (registered).
- done asserts one cycle after the output cycle carrying the final acc_last, i.e. two clocks after the final issue edge. It is high for exactly one cycle, coincident with busy falling.
- D==1: every beat has acc_clear=acc_last=1, valid_b=0, addra=0.
- Counters never exceed the stated ranges; no wrap-around inside a pass. Total issued beats per pass = G*B exactly.
- Reset asserted mid-pass aborts immediately with no done. The next start after reset begins a fresh pass from 0.

Test Plan:
1. Defaults (D=256, B=128, G=16), enable held 1, start pulse -> 2048 consecutive valid cycles. Beat n shows addra=2(n mod 128), addrb=addra+1, weight_addr=n. acc_clear at n mod 128 = 0, acc_last at n mod 128 = 127. group_idx 0..15. done exactly 2 clocks after the final issue edge.
2. INNEURON=20, PI=4, OUTNEURON=8, PO=4 (D=5, B=3, G=2) -> beats (0,1),(2,3),(4,-) with valid_b=0 and addrb=0 on the third. weight_addr 0..5; acc_last on weight_addr 2 and 5.
3. Defaults, enable toggled 1,0,0,1 pattern -> outputs hold during stalls with valid=0. Address sequence identical to scenario 1, only stretched in time. done follows the last valid beat.
4. start pulsed at beats 10 and 500 of a running pass -> ignored; sequence and beat count unchanged, single done.
5. reset driven 0 at beat 300 -> all outputs 0 asynchronously, no done. Fresh start then yields addra=0, weight_addr=0, acc_clear=1 on first valid.
6. D=1 configuration (INNEURON=PI) with G=3 -> three valid beats, each addra=0, valid_b=0, acc_clear=acc_last=1; group_idx 0,1,2; weight_addr 0,1,2.
